// File: rtl/code_pkg.sv
// Shared types and constants for the camera DPCM front end.
//   tempCode_t : one temporary JPEG-DC-style code (valid, size category, magnitude bits)
//   PRED_INIT  : predictor value used for the first pixel of every line
package code_pkg;

  typedef struct packed {
    logic        valid;
    logic [3:0]  size;
    logic [10:0] bits;
  } tempCode_t;

  localparam logic [7:0] PRED_INIT = 8'd128;

endpackage

// File: rtl/code_if.sv
// DVP camera bus: pixel clock, frame sync, line valid and data byte.
//   master : the camera side, drives every signal
//   slave  : the capture side, samples every signal
interface code_if;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] data;

  modport master (output pclk, vsync, href, data);
  modport slave  (input  pclk, vsync, href, data);
endinterface

// File: rtl/code_dpcm_coder.sv
// Per-channel DPCM coder: predicts from the previous pixel of the same row
// (PRED_INIT at the start of a line) and emits size category + magnitude bits.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : one-cycle strobe, val holds a new channel sample
//   first      : sample is column 0 of its line
//   val        : 8-bit channel sample
//   code       : registered code, valid pulses two cycles after en
module dpcm_coder
  import code_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       first,
  input  logic [7:0] val,
  output tempCode_t  code
);

  logic [7:0]        r_pred;
  logic signed [8:0] r_diff_p1;
  logic              r_vld_p1;
  logic [7:0]        w_ref;

  // Bit length of |d|; d never reaches -256 so the magnitude fits in 9 bits.
  function automatic logic [3:0] f_size(input logic signed [8:0] d);
    logic [8:0] mag;
    logic [3:0] s;
    mag = d[8] ? 9'(-d) : 9'(d);
    s   = 4'd0;
    for (int i = 0; i < 9; i++)
      if (mag[i]) s = 4'(i + 1);
    return s;
  endfunction

  // Negative values are coded as the low bits of d-1 (ones' complement of |d|).
  function automatic logic [10:0] f_bits(input logic signed [8:0] d, input logic [3:0] s);
    logic signed [10:0] t;
    logic [10:0]        mask;
    t    = d[8] ? 11'(d) - 11'sd1 : 11'(d);
    mask = (11'd1 << s) - 11'd1;
    return 11'(t) & mask;
  endfunction

  assign w_ref = first ? PRED_INIT : r_pred;

  // Stage p1: difference against predictor, predictor update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred    <= '0;
      r_diff_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= en;
      if (en) begin
        r_diff_p1 <= $signed({1'b0, val}) - $signed({1'b0, w_ref});
        r_pred    <= val;
      end
    end
  end

  // Stage p2: size category and magnitude bits; fields hold between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= '0;
    end else if (r_vld_p1) begin
      code.valid <= 1'b1;
      code.size  <= f_size(r_diff_p1);
      code.bits  <= f_bits(r_diff_p1, f_size(r_diff_p1));
    end else begin
      code.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/code_top.sv
// Camera front end: synchronises the DVP bus into clk, pairs RGB565 bytes into
// pixels, tracks row/column, expands to 8-bit R/G/B and DPCM-codes each channel.
//   clk, rst_n : sole clock, asynchronous active-low reset
//   cam        : DVP bus (pclk, vsync, href, data), sampled as plain data
//   out        : codes, index 0 = R, 1 = G, 2 = B; valid pulses together
module code_top
  import code_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int HEIGHT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  code_if.slave           cam,
  output tempCode_t [2:0] out
);

  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(HEIGHT + 1);
  localparam logic [COL_W-1:0] COL_END = COL_W'(WIDTH);
  localparam logic [ROW_W-1:0] ROW_END = ROW_W'(HEIGHT);

  logic [1:0]       r_pclk_s, r_vsync_s, r_href_s;
  logic [7:0]       r_data_s0, r_data_s1;
  logic             r_pclk_d, r_href_d;
  logic             r_phase;
  logic [7:0]       r_hi;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [15:0]      r_pix_p0;
  logic             r_vld_p0, r_first_p0;
  logic             w_href, w_vsync, w_pclk_rise, w_href_fall, w_take;
  logic [7:0]       w_ch [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pclk_s  <= '0;
      r_vsync_s <= '0;
      r_href_s  <= '0;
      r_data_s0 <= '0;
      r_data_s1 <= '0;
      r_pclk_d  <= 1'b0;
      r_href_d  <= 1'b0;
    end else begin
      r_pclk_s  <= {r_pclk_s[0], cam.pclk};
      r_vsync_s <= {r_vsync_s[0], cam.vsync};
      r_href_s  <= {r_href_s[0], cam.href};
      r_data_s0 <= cam.data;
      r_data_s1 <= r_data_s0;
      r_pclk_d  <= r_pclk_s[1];
      r_href_d  <= r_href_s[1];
    end
  end

  assign w_href      = r_href_s[1];
  assign w_vsync     = r_vsync_s[1];
  assign w_pclk_rise = r_pclk_s[1] & ~r_pclk_d;
  assign w_href_fall = r_href_d & ~w_href;
  assign w_take      = w_pclk_rise & w_href & ~w_vsync;

  // Stage p0: byte pairing and row/column tracking; vsync overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= 1'b0;
      r_hi       <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_pix_p0   <= '0;
      r_vld_p0   <= 1'b0;
      r_first_p0 <= 1'b0;
    end else if (w_vsync) begin
      r_phase  <= 1'b0;
      r_col    <= '0;
      r_row    <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= 1'b0;
      // Dropping the phase while href is low discards a dangling odd byte.
      if (!w_href) r_phase <= 1'b0;
      if (w_href_fall) begin
        r_col <= '0;
        if (r_row != ROW_END) r_row <= r_row + 1'b1;
      end
      if (w_take) begin
        if (!r_phase) begin
          r_hi    <= r_data_s1;
          r_phase <= 1'b1;
        end else begin
          r_phase    <= 1'b0;
          r_pix_p0   <= {r_hi, r_data_s1};
          r_vld_p0   <= (r_col != COL_END) && (r_row != ROW_END);
          r_first_p0 <= (r_col == '0);
          if (r_col != COL_END) r_col <= r_col + 1'b1;
        end
      end
    end
  end

  // Replicate the top bits so full-scale 5/6-bit values map to 255.
  assign w_ch[0] = {r_pix_p0[15:11], r_pix_p0[15:13]};
  assign w_ch[1] = {r_pix_p0[10:5],  r_pix_p0[10:9]};
  assign w_ch[2] = {r_pix_p0[4:0],   r_pix_p0[4:2]};

  for (genvar g = 0; g < 3; g++) begin : g_ch
    dpcm_coder u_coder (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (r_vld_p0),
      .first (r_first_p0),
      .val   (w_ch[g]),
      .code  (out[g])
    );
  end

endmodule

// File: tb/tb_code_top.sv
// Directed bench for code_top: drives DVP lines, predicts codes from a pixel-level
// model and checks every output pulse, plus literal checks of known pixels.
module tb_code_top;
  import code_pkg::*;

  typedef tempCode_t [2:0] trio_t;

  logic  clk, rst_n;
  trio_t out;
  code_if cam ();

  code_top #(.WIDTH(24), .HEIGHT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cam   (cam.slave),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0, bad = 0, n_pulse = 0;
  trio_t exp_q[$];
  trio_t obs[$];
  int    m_row = 0, m_col = 0;
  int    m_prev[3];
  logic [15:0] lq[$];
  logic [2:0]  prev_v = 3'b000;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  function automatic tempCode_t mk(input int s, input int b);
    tempCode_t c;
    c.valid = 1'b1;
    c.size  = 4'(s);
    c.bits  = 11'(b);
    return c;
  endfunction

  function automatic tempCode_t mcode(input int v, input int p);
    int d, m, s, b;
    d = v - p;
    m = (d < 0) ? -d : d;
    s = 0;
    while ((1 << s) <= m) s++;
    b = (d >= 0) ? d : d - 1;
    b = b & ((1 << s) - 1);
    return mk(s, b);
  endfunction

  task automatic model_pixel(input logic [15:0] p);
    int pv, r5, g6, b5;
    int ch[3];
    trio_t e;
    pv = int'(p);
    r5 = (pv >> 11) & 31;
    g6 = (pv >> 5) & 63;
    b5 = pv & 31;
    ch[0] = r5 * 8 + r5 / 4;
    ch[1] = g6 * 4 + g6 / 16;
    ch[2] = b5 * 8 + b5 / 4;
    if (m_col < 24 && m_row < 16) begin
      for (int c = 0; c < 3; c++) e[c] = mcode(ch[c], (m_col == 0) ? 128 : m_prev[c]);
      exp_q.push_back(e);
    end
    for (int c = 0; c < 3; c++) m_prev[c] = ch[c];
    m_col++;
  endtask

  // Compare process: every output pulse is checked against the model queue.
  always @(negedge clk) begin
    logic [2:0] v;
    trio_t e;
    if (rst_n) begin
      v = {out[2].valid, out[1].valid, out[0].valid};
      if (v != 3'b000) begin
        chk("valid_together", 64'(v), 64'(3'b111));
        chk("valid_1cycle", 64'(prev_v), 64'(0));
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'(v), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("R_code", 64'(out[0]), 64'(e[0]));
          chk("G_code", 64'(out[1]), 64'(e[1]));
          chk("B_code", 64'(out[2]), 64'(e[2]));
        end
        obs.push_back(out);
        n_pulse++;
      end
      prev_v = v;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    cam.data = b;
    cam.pclk = 1'b0;
    repeat (4) @(negedge clk);
    cam.pclk = 1'b1;
    repeat (4) @(negedge clk);
    cam.pclk = 1'b0;
  endtask

  task automatic send_line(input bit odd);
    cam.href = 1'b1;
    repeat (4) @(negedge clk);
    foreach (lq[i]) begin
      send_byte(lq[i][15:8]);
      send_byte(lq[i][7:0]);
      model_pixel(lq[i]);
    end
    if (odd) send_byte(8'hA5);
    cam.href = 1'b0;
    repeat (12) @(negedge clk);
    m_col = 0;
    m_row++;
  endtask

  task automatic vsync_pulse();
    cam.vsync = 1'b1;
    repeat (8) @(negedge clk);
    cam.vsync = 1'b0;
    repeat (8) @(negedge clk);
    m_row = 0;
    m_col = 0;
  endtask

  initial begin
    int n0, idx;
    cam.pclk = 1'b0; cam.vsync = 1'b0; cam.href = 1'b0; cam.data = 8'h00;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_out", 64'(out), 64'(0));
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_pulse", 64'(n_pulse), 64'(0));

    // Lines 0 and 1 with hand-computed codes
    lq.delete(); lq.push_back(16'h0000); lq.push_back(16'h0001);
    send_line(1'b0);
    lq.delete(); lq.push_back(16'h000A);
    send_line(1'b0);
    repeat (10) @(negedge clk);
    chk("first_pulses", 64'(n_pulse), 64'(3));
    if (obs.size() >= 3) begin
      chk("l0p0_R", 64'(obs[0][0]), 64'(mk(8, 'h7F)));
      chk("l0p0_G", 64'(obs[0][1]), 64'(mk(8, 'h7F)));
      chk("l0p0_B", 64'(obs[0][2]), 64'(mk(8, 'h7F)));
      chk("l0p1_R", 64'(obs[1][0]), 64'(mk(0, 0)));
      chk("l0p1_G", 64'(obs[1][1]), 64'(mk(0, 0)));
      chk("l0p1_B", 64'(obs[1][2]), 64'(mk(4, 'h8)));
      chk("l1p0_R", 64'(obs[2][0]), 64'(mk(8, 'h7F)));
      chk("l1p0_G", 64'(obs[2][1]), 64'(mk(8, 'h7F)));
      chk("l1p0_B", 64'(obs[2][2]), 64'(mk(6, 'h11)));
    end

    // 25 pixels on a 24-wide line
    vsync_pulse();
    n0 = n_pulse;
    lq.delete();
    for (int i = 0; i < 25; i++) lq.push_back(16'(i * 16'h0841 + i * 7));
    send_line(1'b0);
    repeat (10) @(negedge clk);
    chk("width_clip", 64'(n_pulse - n0), 64'(24));

    // Odd trailing byte dropped; following line must pair correctly
    n0 = n_pulse;
    lq.delete(); lq.push_back(16'hF81F); lq.push_back(16'h07E0);
    send_line(1'b1);
    lq.delete(); lq.push_back(16'h1234);
    send_line(1'b0);
    repeat (10) @(negedge clk);
    chk("odd_byte_drop", 64'(n_pulse - n0), 64'(3));

    // 17th line of a frame produces nothing
    vsync_pulse();
    for (int r = 0; r < 16; r++) begin
      lq.delete(); lq.push_back(16'(r * 16'h1111));
      send_line(1'b0);
    end
    n0 = n_pulse;
    lq.delete(); lq.push_back(16'hFFFF); lq.push_back(16'h0000); lq.push_back(16'h5555);
    send_line(1'b0);
    repeat (10) @(negedge clk);
    chk("height_clip", 64'(n_pulse - n0), 64'(0));

    // vsync mid-line: partial pixel dropped, next line is row 0 with pred 128
    n0 = n_pulse;
    cam.href = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h3C);
    cam.vsync = 1'b1;
    repeat (8) @(negedge clk);
    cam.href = 1'b0;
    repeat (8) @(negedge clk);
    cam.vsync = 1'b0;
    repeat (8) @(negedge clk);
    m_row = 0; m_col = 0;
    chk("vsync_abort", 64'(n_pulse - n0), 64'(0));
    idx = n_pulse;
    lq.delete(); lq.push_back(16'h0000); lq.push_back(16'hFFFF);
    send_line(1'b0);
    repeat (10) @(negedge clk);
    chk("after_vsync_pulses", 64'(n_pulse - idx), 64'(2));
    if (obs.size() >= idx + 2) begin
      chk("vs_p0_R", 64'(obs[idx][0]), 64'(mk(8, 'h7F)));
      chk("vs_p1_B", 64'(obs[idx + 1][2]), 64'(mk(8, 'hFF)));
    end

    // Full frame of ramp data
    vsync_pulse();
    n0 = n_pulse;
    for (int r = 0; r < 16; r++) begin
      lq.delete();
      for (int c = 0; c < 24; c++) lq.push_back(16'((r * 24 + c) * 1009));
      send_line(1'b0);
    end
    repeat (10) @(negedge clk);
    chk("full_frame", 64'(n_pulse - n0), 64'(384));
    chk("model_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
